// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, lock FSM encoding and the ratio/high clamp
// helpers for the multi-channel clock divider.
// Optional feature macro used by the files importing this package:
//   CLK_DIV_PHASE_EN -- per-channel phase offset applied on reconfiguration.
package clk_div_pkg;

  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_LOCK_CYCLES = 16;

  // Lock FSM encoding
  localparam logic [1:0] ST_SETTLE  = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  // A ratio below 2 cannot produce both a high and a low cycle
  function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
    return (ratio < 32'd2) ? 32'd2 : ratio;
  endfunction

  // High time must leave at least one high and one low cycle in the period
  function automatic logic [31:0] clamp_high(input logic [31:0] high,
                                             input logic [31:0] ratio);
    if (high == 32'd0)  return 32'd1;
    if (high >= ratio)  return ratio - 32'd1;
    return high;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: configuration handshake bundle for clk_div_multi.
//   cfg_valid/cfg_ready  request/accept handshake
//   cfg_ch               target channel
//   cfg_ratio/cfg_high   divide ratio and high cycles per period
//   cfg_phase            phase delay (only when CLK_DIV_PHASE_EN is defined)
// master = configuration requester, slave = divider.
interface clk_div_multi_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_ratio;
  logic [CNT_W-1:0] cfg_high;
`ifdef CLK_DIV_PHASE_EN
  logic [CNT_W-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_ratio, cfg_high, cfg_phase,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_ratio, cfg_high, cfg_phase,
                  output cfg_ready);
`else
  modport master (output cfg_valid, cfg_ch, cfg_ratio, cfg_high,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_ratio, cfg_high,
                  output cfg_ready);
`endif

endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel. Free-running counter 0..ratio-1,
// shadow registers loaded (clamped) on capture, and applied at the counter
// wrap while the top level has this channel pending.
//   clk, rst_n      clock, async active-low reset
//   cap             capture cap_ratio/cap_high(/cap_phase) into the shadow
//   pend            this channel has a pending configuration
//   clk_out/clk_en  registered divided clock and first-high-cycle strobe
//   wrap_c          counter is at its last count (combinational)
// With CLK_DIV_PHASE_EN the counter reloads (ratio - phase%ratio)%ratio on apply.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned DEF_RATIO = 4,
  parameter int unsigned DEF_HIGH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap,
  input  logic [CNT_W-1:0] cap_ratio,
  input  logic [CNT_W-1:0] cap_high,
`ifdef CLK_DIV_PHASE_EN
  input  logic [CNT_W-1:0] cap_phase,
`endif
  input  logic             pend,
  output logic             clk_out,
  output logic             clk_en,
  output logic             wrap_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sh_ratio_q, sh_ratio_d;
  logic [CNT_W-1:0] sh_high_q, sh_high_d;
  logic [CNT_W-1:0] reload_c;
  logic [31:0]      cl_ratio_c;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic             apply_c;

  assign wrap_c     = (cnt_q == ratio_q - CNT_W'(1));
  assign apply_c    = pend & wrap_c;
  assign cl_ratio_c = clamp_ratio(32'(cap_ratio));

`ifdef CLK_DIV_PHASE_EN
  logic [CNT_W-1:0] sh_phase_q, sh_phase_d;

  // Starting below zero by phase%ratio delays the first rising edge by that much
  assign reload_c = (sh_ratio_q - (sh_phase_q % sh_ratio_q)) % sh_ratio_q;

  always_comb begin
    sh_phase_d = sh_phase_q;
    if (cap) sh_phase_d = cap_phase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_phase_q <= '0;
    else        sh_phase_q <= sh_phase_d;
  end
`else
  assign reload_c = '0;
`endif

  // Counter, shadow capture and apply; outputs lag the counter by one cycle
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    ratio_d    = ratio_q;
    high_d     = high_q;
    sh_ratio_d = sh_ratio_q;
    sh_high_d  = sh_high_q;
    if (wrap_c) cnt_d = '0;
    if (apply_c) begin
      ratio_d = sh_ratio_q;
      high_d  = sh_high_q;
      cnt_d   = reload_c;
    end
    if (cap) begin
      sh_ratio_d = CNT_W'(cl_ratio_c);
      sh_high_d  = CNT_W'(clamp_high(32'(cap_high), cl_ratio_c));
    end
    clk_out_d = (cnt_q < high_q);
    clk_en_d  = (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      ratio_q    <= CNT_W'(DEF_RATIO);
      high_q     <= CNT_W'(DEF_HIGH);
      sh_ratio_q <= CNT_W'(DEF_RATIO);
      sh_high_q  <= CNT_W'(DEF_HIGH);
      clk_out_q  <= 1'b0;
      clk_en_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      high_q     <= high_d;
      sh_ratio_q <= sh_ratio_d;
      sh_high_q  <= sh_high_d;
      clk_out_q  <= clk_out_d;
      clk_en_q   <= clk_en_d;
    end
  end

  assign clk_out = clk_out_q;
  assign clk_en  = clk_en_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: CH-channel programmable clock divider with a shared
// configuration handshake and a lock flag.
//   clk, rst_n  system clock, async active-low reset
//   cfg         clk_div_multi_if.slave configuration handshake
//   clk_out     registered divided clocks, one per channel
//   clk_en      one-cycle strobe on the first high cycle of each clk_out
//   locked      all channels stable for LOCK_CYCLES
// Optional feature: CLK_DIV_PHASE_EN adds cfg_phase and phase-offset reload.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEF_RATIO   = 4,
  parameter int unsigned DEF_HIGH    = 2,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  clk_div_multi_if.slave        cfg,
  output logic [CH-1:0]         clk_out,
  output logic [CH-1:0]         clk_en,
  output logic                  locked
);

  localparam int unsigned CH_W     = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned SETTLE_W = $clog2(LOCK_CYCLES + 1);

  logic [1:0]          state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
  logic                locked_q, locked_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                accept_c;
  logic [CH-1:0]       cap_c, pend_c, wrap_c;

  assign accept_c = cfg.cfg_valid & cfg_ready_q;

  // Per-channel capture strobe and pending select
  always_comb begin
    cap_c  = '0;
    pend_c = '0;
    for (int i = 0; i < CH; i++) begin
      cap_c[i]  = accept_c && (cfg.cfg_ch == CH_W'(i));
      pend_c[i] = (state_q == ST_PENDING) && (pend_ch_q == CH_W'(i));
    end
  end

  // Lock FSM; an accept for a non-existent channel is dropped
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    pend_ch_d = pend_ch_q;
    case (state_q)
      ST_SETTLE: begin
        if (|cap_c) begin
          state_d   = ST_PENDING;
          pend_ch_d = cfg.cfg_ch;
        end else if (settle_q == SETTLE_W'(LOCK_CYCLES - 1)) begin
          state_d = ST_LOCKED;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_LOCKED: begin
        if (|cap_c) begin
          state_d   = ST_PENDING;
          pend_ch_d = cfg.cfg_ch;
        end
      end
      ST_PENDING: begin
        if (|(wrap_c & pend_c)) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
    endcase
    locked_d    = (state_d == ST_LOCKED);
    cfg_ready_d = (state_d != ST_PENDING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      settle_q    <= '0;
      pend_ch_q   <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      pend_ch_q   <= pend_ch_d;
      locked_q    <= locked_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign locked        = locked_q;
  assign cfg.cfg_ready = cfg_ready_q;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W     (CNT_W),
      .DEF_RATIO (DEF_RATIO),
      .DEF_HIGH  (DEF_HIGH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap       (cap_c[g]),
      .cap_ratio (cfg.cfg_ratio),
      .cap_high  (cfg.cfg_high),
`ifdef CLK_DIV_PHASE_EN
      .cap_phase (cfg.cfg_phase),
`endif
      .pend      (pend_c[g]),
      .clk_out   (clk_out[g]),
      .clk_en    (clk_en[g]),
      .wrap_c    (wrap_c[g])
    );
  end

endmodule
